uart_tx_arbiter: RTL and testbench

- Shares the single uart_tx instance between several byte-stream sources: the byte2ascii daily report, the ADC sample logger and the controller status messages.
- Arbitration is per frame. A granted requester keeps the transmitter until the byte flagged "last" has been sent, or until it stalls past a timeout.
- Sits between the message sources and the uart_tx start/din/done handshake.

---
 rtl/uart_tx_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Per-frame arbiter that shares one uart_tx between NUM_REQ byte-stream sources.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module uart_tx_arbiter #(
    parameter int                NUM_REQ = 3,
    parameter int                TO_BIT  = 20,
    parameter logic [TO_BIT-1:0] TIMEOUT = 20'd1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_din,
    input  logic                 tx_done,
    output logic                 frame_abort,
    output logic                 busy
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BYTE,
        LOAD,
        BUSY
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [PTR_W-1:0]    r_gntIdx;
    logic [PTR_W-1:0]    w_winner;
    logic [NUM_REQ-1:0]  r_grant;
    logic [7:0]          r_txDin;
    logic [7:0]          w_selData;
    logic                r_last;
    logic                r_firstDone;
    logic                r_abort;
    logic [TO_BIT-1:0]   r_toCnt;
    logic                w_selValid;
    logic                w_selLast;
    logic                w_anyValid;
    logic                w_accept;
    logic                w_release;
    logic                w_timeout;

    assign w_anyValid = |req_valid;

    always_comb begin
        w_selValid = 1'b0;
        w_selLast  = 1'b0;
        w_selData  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gntIdx == PTR_W'(i)) begin
                w_selValid = req_valid[i];
                w_selLast  = req_last[i];
                w_selData  = req_data[8*i +: 8];
            end
        end
    end

`ifdef UART_ARB_FIXED_PRIO_EN
    always_comb begin
        w_winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_winner = PTR_W'(i);
            end
        end
    end
`else
    logic [PTR_W-1:0] r_rrPtr;
    int               w_dist;
    int               w_bestDist;

    // Winner is the valid requester at the smallest upward distance from rr_ptr.
    always_comb begin
        w_winner   = '0;
        w_dist     = 0;
        w_bestDist = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i >= int'(r_rrPtr)) ? (i - int'(r_rrPtr)) : (i + NUM_REQ - int'(r_rrPtr));
            if (req_valid[i] && (w_dist < w_bestDist)) begin
                w_bestDist = w_dist;
                w_winner   = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rrPtr <= '0;
        end else if (w_release) begin
            r_rrPtr <= (r_gntIdx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gntIdx + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_anyValid) begin
                    w_nextState = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                if (w_selValid) begin
                    w_accept    = 1'b1;
                    w_nextState = LOAD;
                end else if (r_firstDone && (r_toCnt == TIMEOUT - 1'b1)) begin
                    w_timeout   = 1'b1;
                    w_release   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            LOAD: begin
                w_nextState = BUSY;
            end
            BUSY: begin
                if (tx_done) begin
                    if (r_last) begin
                        w_release   = 1'b1;
                        w_nextState = IDLE;
                    end else begin
                        w_nextState = WAIT_BYTE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Stall counter only runs between bytes of a frame that has already started.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_toCnt <= '0;
        end else if ((r_state == WAIT_BYTE) && r_firstDone && !w_accept && !w_timeout) begin
            if (r_toCnt != '1) begin
                r_toCnt <= r_toCnt + 1'b1;
            end
        end else begin
            r_toCnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant     <= '0;
            r_gntIdx    <= '0;
            r_txDin     <= 8'h00;
            r_last      <= 1'b0;
            r_firstDone <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_abort <= w_timeout;
            if ((r_state == IDLE) && w_anyValid) begin
                r_grant     <= NUM_REQ'(1) << w_winner;
                r_gntIdx    <= w_winner;
                r_firstDone <= 1'b0;
            end else if (w_release) begin
                r_grant <= '0;
            end
            if (w_accept) begin
                r_txDin     <= w_selData;
                r_last      <= w_selLast;
                r_firstDone <= 1'b1;
            end
        end
    end

    assign grant       = r_grant;
    assign req_ready   = (r_state == WAIT_BYTE) ? r_grant : '0;
    assign tx_start    = (r_state == LOAD);
    assign tx_din      = r_txDin;
    assign frame_abort = r_abort;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: random byte sources and a uart_tx stand-in,
// compared every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int N   = 3;
    localparam int TMO = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] gap;
    } srcByte_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   reqValid;
    logic [8*N-1:0] reqData;
    logic [N-1:0]   reqLast;
    logic           txDone;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [7:0]     tx_din;
    logic           frame_abort;
    logic           busy;

    uart_tx_arbiter #(.NUM_REQ(N), .TO_BIT(20), .TIMEOUT(20'd8)) dut (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_data(reqData), .req_last(reqLast),
        .req_ready(req_ready), .grant(grant), .tx_start(tx_start), .tx_din(tx_din),
        .tx_done(txDone), .frame_abort(frame_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    int errorCount = 0;
    int checkCount = 0;

    srcByte_t     srcQ[N][$];
    int           gapCnt[N];
    logic [N-1:0] readyBefore;
    int           doneCd;
    int           uartDelay;
    bit           randDelay;
    int           strayRate;
    int           rstRate;

    int           mOwner;
    int           mPtr;
    int           mStall;
    bit           mWaiting;
    bit           mStarting;
    bit           mSending;
    bit           mStarted;
    bit           mLastByte;
    bit           mAbort;
    logic [7:0]   mDin;

    int           grantLog[$];
    int           startLog[$];
    int           startCount;
    int           abortCount;
    logic [N-1:0] prevGrant;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Next owner from the requests present at an arbitration edge.
    function automatic int pickWinner(input logic [N-1:0] v, input int ptr);
        int idx;
        pickWinner = -1;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int k = N - 1; k >= 0; k--) begin
            if (v[k]) pickWinner = k;
        end
`else
        for (int k = N - 1; k >= 0; k--) begin
            idx = (ptr + k) % N;
            if (v[idx]) pickWinner = idx;
        end
`endif
    endfunction

    function automatic int logAt(input int q[$], input int i);
        logAt = (q.size() > i) ? q[i] : 32'hDEAD;
    endfunction

    function automatic bit allIdle();
        allIdle = (reqValid == '0) && (mOwner < 0) && (doneCd == 0);
        for (int i = 0; i < N; i++) begin
            if (srcQ[i].size() != 0) allIdle = 1'b0;
        end
    endfunction

    // Frame-level view of one clock edge, driven by the inputs present at that edge.
    task automatic modelEdge();
        mAbort = 1'b0;
        if (rst) begin
            mOwner = -1; mPtr = 0; mStall = 0; mDin = 8'h00;
            mWaiting = 0; mStarting = 0; mSending = 0; mStarted = 0; mLastByte = 0;
        end else if (mOwner < 0) begin
            if (reqValid != '0) begin
                mOwner = pickWinner(reqValid, mPtr);
                mWaiting = 1; mStarted = 0; mStall = 0;
            end
        end else if (mWaiting) begin
            if (reqValid[mOwner]) begin
                mDin = reqData[8*mOwner +: 8];
                mLastByte = reqLast[mOwner];
                mWaiting = 0; mStarting = 1; mStarted = 1; mStall = 0;
            end else if (mStarted) begin
                mStall++;
                if (mStall == TMO) begin
                    mAbort = 1'b1;
`ifndef UART_ARB_FIXED_PRIO_EN
                    mPtr = (mOwner + 1) % N;
`endif
                    mOwner = -1; mWaiting = 0; mStall = 0;
                end
            end
        end else if (mStarting) begin
            mStarting = 0; mSending = 1;
        end else if (mSending && txDone) begin
            mSending = 0;
            if (mLastByte) begin
                mPtr = (mOwner + 1) % N;
                mOwner = -1;
            end else begin
                mWaiting = 1;
            end
        end
    endtask

    // One clock: model the edge, compare outputs, then drive sources and uart for the next edge.
    task automatic applyStimulus();
        logic [N-1:0] acc;
        @(posedge clk);
        #1;
        modelEdge();
        checkOutput("grant", 32'(grant), (mOwner >= 0) ? (32'd1 << mOwner) : 32'd0);
        checkOutput("ready", 32'(req_ready), (mOwner >= 0 && mWaiting) ? (32'd1 << mOwner) : 32'd0);
        checkOutput("txStart", 32'(tx_start), 32'(mStarting));
        checkOutput("txDin", 32'(tx_din), 32'(mDin));
        checkOutput("abort", 32'(frame_abort), 32'(mAbort));
        checkOutput("busy", 32'(busy), (mOwner >= 0) ? 32'd1 : 32'd0);

        if (grant != '0 && prevGrant == '0) grantLog.push_back(int'(grant));
        prevGrant = grant;
        if (tx_start) begin
            startLog.push_back(int'(tx_din));
            startCount++;
        end
        if (frame_abort) abortCount++;

        acc = reqValid & readyBefore & {N{~rst}};
        readyBefore = req_ready;
        rst = (rstRate > 0) && ($urandom_range(rstRate - 1, 0) == 0);

        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                void'(srcQ[i].pop_front());
                gapCnt[i] = 0;
                reqValid[i] = 1'b0;
            end
            if (!reqValid[i]) begin
                if (srcQ[i].size() > 0) begin
                    if (gapCnt[i] >= int'(srcQ[i][0].gap)) begin
                        reqValid[i] = 1'b1;
                        reqData[8*i +: 8] = srcQ[i][0].data;
                        reqLast[i] = srcQ[i][0].last;
                    end else begin
                        gapCnt[i]++;
                    end
                end
                if (!reqValid[i]) begin
                    reqData[8*i +: 8] = 8'($urandom);
                    reqLast[i] = 1'($urandom);
                end
            end
        end

        txDone = 1'b0;
        if (tx_start) doneCd = randDelay ? int'($urandom_range(6, 1)) : uartDelay;
        if (doneCd > 0) begin
            doneCd--;
            if (doneCd == 0) txDone = 1'b1;
        end else if (strayRate > 0 && $urandom_range(strayRate - 1, 0) == 0) begin
            txDone = 1'b1;
        end
    endtask

    task automatic pushByte(input int r, input logic [7:0] d, input logic l, input int gap);
        srcQ[r].push_back({d, l, 8'(gap)});
    endtask

    task automatic pushFrames(input int r, input int frames, input int len, input logic [7:0] base);
        for (int f = 0; f < frames; f++) begin
            for (int b = 0; b < len; b++) begin
                pushByte(r, base + 8'(16 * f + b), (b == len - 1), 0);
            end
        end
    endtask

    task automatic clearLogs();
        grantLog.delete();
        startLog.delete();
        startCount = 0;
        abortCount = 0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus();
        clearLogs();
    endtask

    task automatic runDrain(input string tag, input int budget);
        int n = 0;
        while (!allIdle() && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, 32'(allIdle()), 32'd1);
    endtask

    initial begin
        int n;
        int snap;
        rst = 1'b1; reqValid = '0; reqData = '0; reqLast = '0; txDone = 1'b0;
        readyBefore = '0; doneCd = 0; uartDelay = 20; randDelay = 0; strayRate = 0; rstRate = 0;
        prevGrant = '0; mOwner = -1; mPtr = 0; mDin = 8'h00;
        for (int i = 0; i < N; i++) gapCnt[i] = 0;
        clearLogs();

        $display("[TB] reset and single frame from requester 1");
        applyStimulus();
        checkOutput("rstGrant", 32'(grant), 32'd0);
        checkOutput("rstDin", 32'(tx_din), 32'd0);
        clearLogs();
        pushByte(1, 8'h41, 1'b0, 0);
        pushByte(1, 8'h42, 1'b0, 0);
        pushByte(1, 8'h0A, 1'b1, 0);
        runDrain("singleDrain", 200);
        checkOutput("singleGrant", 32'(logAt(grantLog, 0)), 32'b010);
        checkOutput("singleStarts", 32'(startCount), 32'd3);
        checkOutput("singleByte0", 32'(logAt(startLog, 0)), 32'h41);
        checkOutput("singleByte1", 32'(logAt(startLog, 1)), 32'h42);
        checkOutput("singleByte2", 32'(logAt(startLog, 2)), 32'h0A);
        checkOutput("singleAborts", 32'(abortCount), 32'd0);

        $display("[TB] all requesters streaming 2-byte frames");
        uartDelay = 3;
        doReset();
        pushFrames(0, 4, 2, 8'h00);
        pushFrames(1, 4, 2, 8'h80);
        pushFrames(2, 4, 2, 8'hC0);
        runDrain("rrDrain", 600);
`ifdef UART_ARB_FIXED_PRIO_EN
        checkOutput("rrGrant1", 32'(logAt(grantLog, 1)), 32'b001);
        checkOutput("rrGrant3", 32'(logAt(grantLog, 3)), 32'b001);
        checkOutput("rrGrant4", 32'(logAt(grantLog, 4)), 32'b010);
`else
        checkOutput("rrGrant1", 32'(logAt(grantLog, 1)), 32'b010);
        checkOutput("rrGrant2", 32'(logAt(grantLog, 2)), 32'b100);
        checkOutput("rrGrant3", 32'(logAt(grantLog, 3)), 32'b001);
`endif
        checkOutput("rrGrant0", 32'(logAt(grantLog, 0)), 32'b001);

        $display("[TB] inter-byte timeout on requester 0");
        doReset();
        pushByte(0, 8'h10, 1'b0, 0);
        pushByte(0, 8'h11, 1'b1, 30);
        pushFrames(1, 1, 2, 8'h20);
        runDrain("toDrain", 300);
        checkOutput("toAborts", 32'(abortCount), 32'd1);
        checkOutput("toGrant0", 32'(logAt(grantLog, 0)), 32'b001);
        checkOutput("toGrant1", 32'(logAt(grantLog, 1)), 32'b010);

        $display("[TB] reset while a byte is on the line");
        uartDelay = 20;
        doReset();
        pushFrames(1, 1, 2, 8'h55);
        n = 0;
        while (startCount == 0 && n < 60) begin
            applyStimulus();
            n++;
        end
        checkOutput("midReachBusy", 32'(startCount), 32'd1);
        for (int k = 0; k < 3; k++) applyStimulus();
        for (int i = 0; i < N; i++) srcQ[i].delete();
        reqValid = '0;
        rst = 1'b1;
        applyStimulus();
        checkOutput("midGrant", 32'(grant), 32'd0);
        checkOutput("midBusy", 32'(busy), 32'd0);
        checkOutput("midDin", 32'(tx_din), 32'd0);
        snap = startCount;
        for (int k = 0; k < 30; k++) applyStimulus();
        checkOutput("midStrayStart", 32'(startCount), 32'(snap));

        $display("[TB] stray tx_done in IDLE and while waiting for a byte");
        uartDelay = 2;
        doReset();
        txDone = 1'b1;
        applyStimulus();
        checkOutput("strayIdleGrant", 32'(grant), 32'd0);
        checkOutput("strayIdleStart", 32'(startCount), 32'd0);
        pushByte(2, 8'hA1, 1'b0, 0);
        pushByte(2, 8'hA2, 1'b1, 5);
        n = 0;
        while (!(req_ready[2] && !reqValid[2] && startCount == 1) && n < 80) begin
            applyStimulus();
            n++;
        end
        checkOutput("strayReachWait", 32'(n < 80), 32'd1);
        snap = startCount;
        txDone = 1'b1;
        applyStimulus();
        checkOutput("strayWaitGrant", 32'(grant), 32'b100);
        checkOutput("strayWaitStart", 32'(startCount), 32'(snap));
        runDrain("strayDrain", 200);

        $display("[TB] requesters 0 and 2 competing");
        uartDelay = 3;
        doReset();
        pushFrames(0, 3, 2, 8'h30);
        pushFrames(2, 2, 2, 8'h60);
        runDrain("prioDrain", 400);
`ifdef UART_ARB_FIXED_PRIO_EN
        checkOutput("prioGrant1", 32'(logAt(grantLog, 1)), 32'b001);
        checkOutput("prioGrant2", 32'(logAt(grantLog, 2)), 32'b001);
        checkOutput("prioGrant3", 32'(logAt(grantLog, 3)), 32'b100);
`else
        checkOutput("prioGrant1", 32'(logAt(grantLog, 1)), 32'b100);
        checkOutput("prioGrant2", 32'(logAt(grantLog, 2)), 32'b001);
        checkOutput("prioGrant3", 32'(logAt(grantLog, 3)), 32'b100);
`endif
        checkOutput("prioGrant0", 32'(logAt(grantLog, 0)), 32'b001);

        $display("[TB] randomized traffic");
        doReset();
        randDelay = 1; strayRate = 40; rstRate = 500;
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(1, 0) == 1) begin
                    n = int'($urandom_range(4, 1));
                    for (int b = 0; b < n; b++) begin
                        pushByte(i, 8'($urandom), (b == n - 1),
                                 ($urandom_range(7, 0) == 0) ? int'($urandom_range(12, 9)) : int'($urandom_range(3, 0)));
                    end
                end
            end
            for (int k = 0; k < 80; k++) applyStimulus();
        end
        strayRate = 0; rstRate = 0;
        runDrain("randDrain", 5000);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
